// File: rtl/fifo_stream_reader_if.sv
// Bundle between the fifo read port, the stream reader and its downstream consumer.
// master = the reader; slave = whatever drives the fifo flags and the ready.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [1:0]            buf_count;
    logic [CNT_WIDTH-1:0]  word_count;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd, m_valid, m_data, buf_count, word_count
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd, m_valid, m_data, buf_count, word_count
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops the fifo and presents words on a valid/ready stream through a 3-entry skid buffer.
// Latency: first word on m_data 2 cycles after fifo_empty falls; sustains 1 word/cycle.
// Backpressure: m_ready low holds m_data/m_valid; reads stop once held + in-flight words reach 3.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input logic                  clk,
    input logic                  rst,
    fifo_stream_reader_if.master bus
);
    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [1:0]            occ;
    logic                  pend;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [2:0]            credit_used;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Each word in flight already owns a slot, so fifo_rd never looks at m_ready.
    assign credit_used    = {1'b0, occ} + {2'b00, pend};
    assign bus.fifo_rd    = !rst && !bus.fifo_empty && (credit_used < 3'd3);

    assign push           = pend;
    assign pop            = bus.m_valid && bus.m_ready;

    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = mem[head];
    assign bus.buf_count  = occ;
    assign bus.word_count = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
            head <= 2'd0;
            tail <= 2'd0;
            occ  <= 2'd0;
            pend <= 1'b0;
            cnt  <= '0;
        end else begin
            pend <= bus.fifo_rd;
            if (push) begin
                mem[tail] <= bus.fifo_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
                cnt  <= cnt + CNT_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // A capture into a full buffer would mean the credit rule above is broken.
    assert property (@(posedge clk) disable iff (rst) !(push && occ == 2'd3));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural fifo model and an in-order scoreboard.
module tb_fifo_stream_reader;
    localparam int DW = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();
    fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic          fifo_clr = 1'b1;
    logic          wr       = 1'b0;
    logic [DW-1:0] wr_word  = '0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];
    logic          mon_en   = 1'b0;
    int            rd_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // Fifo model: data_out registered on a read of a non-empty fifo, empty flag registered.
    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
            bus.fifo_data  <= '0;
            bus.fifo_empty <= 1'b1;
        end else begin
            if (bus.fifo_rd && !bus.fifo_empty) bus.fifo_data <= fq.pop_front();
            if (wr) fq.push_back(wr_word);
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // Stream monitor: order against the scoreboard plus hold-while-stalled.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_rd) rd_cnt++;
            if (mon_en) begin
                chk("valid_vs_count", {31'd0, bus.m_valid}, {31'd0, bus.buf_count != 2'd0});
                if (prev_stall) begin
                    chk("hold_valid", {31'd0, bus.m_valid}, 32'd1);
                    chk("hold_data", {30'd0, bus.m_data}, {30'd0, prev_data});
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got %0h expected no word", bus.m_data);
                    end else begin
                        chk("stream_data", {30'd0, bus.m_data}, {30'd0, sb.pop_front()});
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    typedef struct {
        logic          rst;
        logic          wr;
        logic [DW-1:0] w;
        logic          rdy;
        logic          e_rd;
        logic          e_v;
        logic [DW-1:0] e_d;
        logic          chk_d;
        logic [1:0]    e_bc;
        logic [CW-1:0] e_wc;
    } vec_t;

    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        int first, run, n, exp_wc;
        logic done, pr, found;

        //         rst wr  w    rdy  rd v  d    chkd bc wc
        vt[0]  = '{1, 1, 2'd2, 1,  0, 0, 2'd0, 1, 0, 0};
        vt[1]  = '{1, 0, 2'd0, 1,  0, 0, 2'd0, 1, 0, 0};
        vt[2]  = '{1, 0, 2'd0, 1,  0, 0, 2'd0, 1, 0, 0};
        vt[3]  = '{1, 0, 2'd0, 1,  0, 0, 2'd0, 1, 0, 0};
        vt[4]  = '{0, 0, 2'd0, 1,  1, 0, 2'd0, 1, 0, 0};
        vt[5]  = '{0, 0, 2'd0, 1,  0, 0, 2'd0, 1, 0, 0};
        vt[6]  = '{0, 0, 2'd0, 1,  0, 1, 2'd2, 1, 1, 0};
        vt[7]  = '{0, 1, 2'd1, 0,  0, 0, 2'd0, 0, 0, 1};
        vt[8]  = '{0, 1, 2'd3, 0,  1, 0, 2'd0, 0, 0, 1};
        vt[9]  = '{0, 0, 2'd0, 0,  1, 0, 2'd0, 0, 0, 1};
        vt[10] = '{0, 0, 2'd0, 0,  0, 1, 2'd1, 1, 1, 1};
        vt[11] = '{0, 0, 2'd0, 1,  0, 1, 2'd1, 1, 2, 1};
        vt[12] = '{0, 0, 2'd0, 1,  0, 1, 2'd3, 1, 1, 2};
        vt[13] = '{0, 0, 2'd0, 1,  0, 0, 2'd0, 0, 0, 3};

        bus.m_ready = 1'b0;
        @(posedge clk); #2;
        fifo_clr = 1'b0;

        for (int i = 0; i < 14; i++) begin
            rst         = vt[i].rst;
            wr          = vt[i].wr;
            wr_word     = vt[i].w;
            bus.m_ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_fifo_rd", i), {31'd0, bus.fifo_rd}, {31'd0, vt[i].e_rd});
            chk($sformatf("vec%0d_m_valid", i), {31'd0, bus.m_valid}, {31'd0, vt[i].e_v});
            if (vt[i].chk_d)
                chk($sformatf("vec%0d_m_data", i), {30'd0, bus.m_data}, {30'd0, vt[i].e_d});
            chk($sformatf("vec%0d_buf_count", i), {30'd0, bus.buf_count}, {30'd0, vt[i].e_bc});
            chk($sformatf("vec%0d_word_count", i), {16'd0, bus.word_count}, {16'd0, vt[i].e_wc});
            @(posedge clk); #2;
        end
        exp_wc = 3;

        // Streaming: 32 back-to-back words with the sink always ready.
        mon_en = 1'b1;
        bus.m_ready = 1'b1;
        first = -1; run = 0; done = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (c < 32) begin
                w = DW'($urandom);
                wr = 1'b1; wr_word = w; sb.push_back(w);
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            if (bus.m_valid) begin
                if (first < 0) first = c;
                if (!done) run++;
            end else if (first >= 0) begin
                done = 1'b1;
            end
            @(posedge clk); #2;
        end
        exp_wc += 32;
        chk("stream_latency", first, 32'd3);
        chk("stream_run", run, 32'd32);
        chk("stream_drained", sb.size(), 32'd0);
        chk("stream_word_count", {16'd0, bus.word_count}, exp_wc);

        // Backpressure: 8 words queued against a stalled sink.
        bus.m_ready = 1'b0;
        rd_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (c < 8) begin
                w = DW'($urandom);
                wr = 1'b1; wr_word = w; sb.push_back(w);
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            @(posedge clk); #2;
        end
        @(negedge clk);
        chk("bp_rd_pulses", rd_cnt, 32'd3);
        chk("bp_buf_count", {30'd0, bus.buf_count}, 32'd3);
        chk("bp_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);
        chk("bp_head_data", {30'd0, bus.m_data}, {30'd0, sb[0]});
        @(posedge clk); #2;
        bus.m_ready = 1'b1;
        run = 0; done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.m_valid && !done) run++;
            else done = 1'b1;
            @(posedge clk); #2;
        end
        exp_wc += 8;
        chk("bp_run", run, 32'd8);
        chk("bp_drained", sb.size(), 32'd0);
        chk("bp_word_count", {16'd0, bus.word_count}, exp_wc);

        // Sparse writes against a randomly ready sink.
        n = 0;
        for (int c = 0; c < 3000 && (n < 200 || sb.size() != 0); c++) begin
            bus.m_ready = 1'($urandom_range(0, 1));
            if ((c % 2 == 0) && n < 200) begin
                w = DW'($urandom);
                wr = 1'b1; wr_word = w; sb.push_back(w);
                n++;
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            @(posedge clk); #2;
        end
        wr = 1'b0;
        if (n < 200 || sb.size() != 0) timeout("random_drain");
        exp_wc += 200;
        chk("random_word_count", {16'd0, bus.word_count}, exp_wc);

        // Reset while a word is in flight and two are held.
        bus.m_ready = 1'b0;
        pr = 1'b0; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (c < 5) begin
                w = DW'($urandom);
                wr = 1'b1; wr_word = w; sb.push_back(w);
            end else begin
                wr = 1'b0;
            end
            @(negedge clk);
            if (bus.buf_count == 2'd2 && pr) begin
                found = 1'b1;
            end else begin
                pr = bus.fifo_rd;
                @(posedge clk); #2;
            end
        end
        if (!found) timeout("midreset_setup");
        #1;
        rst = 1'b1; fifo_clr = 1'b1; wr = 1'b0;
        sb.delete();
        #1;
        chk("midreset_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("midreset_m_data", {30'd0, bus.m_data}, 32'd0);
        chk("midreset_buf_count", {30'd0, bus.buf_count}, 32'd0);
        chk("midreset_word_count", {16'd0, bus.word_count}, 32'd0);
        chk("midreset_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        fifo_clr = 1'b0; rst = 1'b0;
        bus.m_ready = 1'b1;
        wr = 1'b1; wr_word = 2'd1; sb.push_back(2'd1);
        @(posedge clk); #2;
        wr = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() != 0) timeout("midreset_first_word");
        @(negedge clk);
        chk("midreset_post_word_count", {16'd0, bus.word_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
